// File: rtl/config_loader_pkg.sv
// Shared types and constants for the config-chain loader.
// The readback path (CFG_LOADER_READBACK_EN) uses the CRC constants and step function.
package config_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    VERIFY,
    FINISH
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One serial CRC-8 step, MSB-first feedback.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/cfg_crc8.sv
// Bit-serial CRC-8 accumulator (poly 0x07). clr restarts at CRC8_INIT,
// en folds in one bit per cycle.
module cfg_crc8
  import config_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  // CRC register: clear has priority over accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      crc <= CRC8_INIT;
    else if (clr) crc <= CRC8_INIT;
    else if (en)  crc <= crc8_step(crc, din);
  end

endmodule

// File: rtl/config_loader.sv
// Streams bitstream words MSB-first into a serial configuration chain.
// Optional readback: define CFG_LOADER_READBACK_EN to add a VERIFY pass that
// recirculates the chain once and compares CRC-8 of sent vs returned bits.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 48,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              cfg_en,
  output logic              cfg_data,
  input  logic              cfg_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WCNT_W-1:0] LAST_WBIT = WCNT_W'(WORD_W - 1);

  state_t             state, state_nxt;
  logic [WORD_W-1:0]  shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WCNT_W-1:0]  word_cnt;
  logic               last_bit, last_wbit;

  assign last_bit  = (bit_cnt == LAST_BIT);
  assign last_wbit = (word_cnt == LAST_WBIT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and Moore outputs; all outputs fall to 0 as soon as reset forces IDLE.
  always_comb begin
    state_nxt  = state;
    word_ready = 1'b0;
    cfg_en     = 1'b0;
    cfg_data   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        word_ready = 1'b1;
        if (word_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        cfg_en   = 1'b1;
        cfg_data = shreg[WORD_W-1];
        // The chain-length test wins, so a partial last word has its low bits dropped.
        if (last_bit) begin
`ifdef CFG_LOADER_READBACK_EN
          state_nxt = VERIFY;
`else
          state_nxt = FINISH;
`endif
        end else if (last_wbit) begin
          state_nxt = LOAD;
        end
      end
`ifdef CFG_LOADER_READBACK_EN
      VERIFY: begin
        // Feeding the tail back into the head restores the chain after CHAIN_LEN shifts.
        cfg_en   = 1'b1;
        cfg_data = cfg_tail;
        if (last_bit) state_nxt = FINISH;
      end
`endif
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word shift register and bit/word counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) bit_cnt <= '0;
        LOAD: begin
          word_cnt <= '0;
          if (word_valid) shreg <= word_data;
        end
        SHIFT: begin
          shreg    <= shreg << 1;
          word_cnt <= word_cnt + 1'b1;
`ifdef CFG_LOADER_READBACK_EN
          // Restart the count so VERIFY can time its own CHAIN_LEN-cycle pass.
          bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
`else
          bit_cnt  <= bit_cnt + 1'b1;
`endif
        end
`ifdef CFG_LOADER_READBACK_EN
        VERIFY: bit_cnt <= bit_cnt + 1'b1;
`endif
        default: ;
      endcase
    end
  end

`ifdef CFG_LOADER_READBACK_EN
  logic [7:0] crc_tx, crc_rb;
  logic       crc_clr;

  assign crc_clr = (state == IDLE) && start;

  cfg_crc8 u_crc_tx (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (state == SHIFT),
    .din (shreg[WORD_W-1]),
    .crc (crc_tx)
  );

  cfg_crc8 u_crc_rb (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (state == VERIFY),
    .din (cfg_tail),
    .crc (crc_rb)
  );

  // Sticky mismatch flag; the last returned bit is folded in combinationally so
  // the verdict is ready by the time FINISH is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      error <= 1'b0;
    else if (crc_clr)
      error <= 1'b0;
    else if ((state == VERIFY) && last_bit && (crc_tx != crc8_step(crc_rb, cfg_tail)))
      error <= 1'b1;
  end
`else
  logic unused_tail;
  assign unused_tail = cfg_tail;
  assign error       = 1'b0;
`endif

endmodule
